// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge
// Bridges the multi-cycle core memory port to a variable-latency req/ack memory.
// Features: registered request with timeout, alignment and strobe sanity checks,
// a sticky bus_err flag and one-cycle core_ready completion pulses.
// Optional build macro MEM_BRIDGE_WRITE_POST_EN: posted writes (WPEND state),
// where the core is released one cycle after a legal write is accepted.
module mem_bus_bridge #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              core_rd,
   input  logic              core_wr,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic [DATA_W-1:0] core_rdata,
   output logic              core_ready,
   output logic              core_busy,
   output logic              bus_err,
   input  logic              err_clr,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

`ifdef MEM_BRIDGE_WRITE_POST_EN
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_DONE  = 3'd2,
      ST_ERR   = 3'd3,
      ST_WPEND = 3'd4
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } state_t;
`endif

   state_t          state_r;
   logic [TO_W-1:0] cnt_r;

   logic            req_any_s;
   logic            req_bad_s;
   logic [TO_W-1:0] cnt_inc_s;
   logic            timeout_s;

   // A request is anything strobed; it is illegal if misaligned or both strobes are high.
   assign req_any_s = core_rd | core_wr;
   assign req_bad_s = (core_addr[1:0] != 2'b00) | (core_rd & core_wr);

   // The wait counter expires on the edge where it would reach TIMEOUT.
   assign cnt_inc_s = cnt_r + TO_W'(1);
   assign timeout_s = (cnt_inc_s == TO_W'(TIMEOUT));

   // Transaction FSM with all core- and memory-side outputs registered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= ST_IDLE;
         cnt_r      <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         core_rdata <= '0;
         core_ready <= 1'b0;
         core_busy  <= 1'b0;
         bus_err    <= 1'b0;
      end else begin
         // Ready is a single-cycle pulse; only the arms below raise it.
         core_ready <= 1'b0;
         // Clear is applied first so that an error set later in this block wins.
         if (err_clr) begin
            bus_err <= 1'b0;
         end
         case (state_r)
            ST_IDLE: begin
               if (req_any_s) begin
                  mem_we    <= core_wr;
                  mem_addr  <= core_addr;
                  mem_wdata <= core_wdata;
                  core_busy <= 1'b1;
                  if (req_bad_s) begin
                     // Illegal request: never touch memory, report through ERR.
                     state_r    <= ST_ERR;
                     bus_err    <= 1'b1;
                     core_rdata <= '1;
                  end else begin
                     cnt_r   <= '0;
                     mem_req <= 1'b1;
`ifdef MEM_BRIDGE_WRITE_POST_EN
                     if (core_wr) begin
                        // Posted write: release the core now, finish the bus side in WPEND.
                        state_r    <= ST_WPEND;
                        core_ready <= 1'b1;
                     end else begin
                        state_r <= ST_REQ;
                     end
`else
                     state_r <= ST_REQ;
`endif
                  end
               end
            end
            ST_REQ: begin
               cnt_r <= cnt_inc_s;
               if (mem_ack) begin
                  mem_req    <= 1'b0;
                  core_ready <= 1'b1;
                  state_r    <= ST_DONE;
                  if (!mem_we) begin
                     core_rdata <= mem_rdata;
                  end
               end else if (timeout_s) begin
                  mem_req    <= 1'b0;
                  bus_err    <= 1'b1;
                  core_rdata <= '1;
                  state_r    <= ST_ERR;
               end
            end
            ST_ERR: begin
               // Error still completes the access so the core is never left stalled.
               core_ready <= 1'b1;
               state_r    <= ST_DONE;
            end
            ST_DONE: begin
               // Ready pulse is visible in this cycle; strobes are re-examined in IDLE.
               core_busy <= 1'b0;
               state_r   <= ST_IDLE;
            end
`ifdef MEM_BRIDGE_WRITE_POST_EN
            ST_WPEND: begin
               cnt_r <= cnt_inc_s;
               if (mem_ack) begin
                  mem_req   <= 1'b0;
                  core_busy <= 1'b0;
                  state_r   <= ST_IDLE;
               end else if (timeout_s) begin
                  // The ready pulse was already given, so only the flag reports this.
                  mem_req   <= 1'b0;
                  bus_err   <= 1'b1;
                  core_busy <= 1'b0;
                  state_r   <= ST_IDLE;
               end
            end
`endif
            default: begin
               mem_req   <= 1'b0;
               core_busy <= 1'b0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
